// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared sizing, register index constants and reset defaults for the mips core
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;

  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam word_t SP_INIT = 32'h8012_0000;
  localparam word_t RA_INIT = 32'h0000_0000;

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - 2-read/1-write register file, R0 hardwired to zero
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile
  import mips_pkg::*;
#(
  parameter int                 DATA_W   = mips_pkg::DATA_W,
  parameter int                 NUM_REGS = mips_pkg::NUM_REGS,
  parameter int                 ADDR_W   = mips_pkg::ADDR_W,
  parameter logic [DATA_W-1:0]  SP_INIT  = mips_pkg::SP_INIT,
  parameter logic [DATA_W-1:0]  RA_INIT  = mips_pkg::RA_INIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] wr_num,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] rd0_num,
  output logic [DATA_W-1:0] rd0_data,
  input  logic [ADDR_W-1:0] rd1_num,
  output logic [DATA_W-1:0] rd1_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Index 0 and indices beyond NUM_REGS are never stored or returned.
  function automatic logic in_range(input logic [ADDR_W-1:0] num);
    return (num != ADDR_W'(REG_ZERO)) && (int'(num) < NUM_REGS);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i == REG_SP)      regs[i] <= SP_INIT;
        else if (i == REG_RA) regs[i] <= RA_INIT;
        else                  regs[i] <= '0;
      end
    end else if (wr_en && in_range(wr_num)) begin
      regs[wr_num] <= wr_data;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] num);
    if (!in_range(num)) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (num == wr_num)) return wr_data;
`endif
    return regs[num];
  endfunction

  assign rd0_data = read_port(rd0_num);
  assign rd1_data = read_port(rd1_num);

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - directed scoreboard bench for regfile
module tb_regfile;
  import mips_pkg::*;

  logic     clk = 1'b0;
  logic     reset = 1'b0;
  reg_idx_t wr_num = '0;
  word_t    wr_data = '0;
  logic     wr_en = 1'b0;
  reg_idx_t rd0_num = '0;
  word_t    rd0_data;
  reg_idx_t rd1_num = '0;
  word_t    rd1_data;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string tag;
    word_t exp;
  } exp_t;

  exp_t sb[$];

  regfile dut (
    .clk      (clk),
    .reset    (reset),
    .wr_num   (wr_num),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .rd0_num  (rd0_num),
    .rd0_data (rd0_data),
    .rd1_num  (rd1_num),
    .rd1_data (rd1_data)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input string tag, input word_t v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input word_t obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Drive a write during the low phase; it commits on the next rising edge.
  task automatic do_write(input reg_idx_t n, input word_t d);
    wr_num  = n;
    wr_data = d;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic read2(input reg_idx_t a0, input reg_idx_t a1);
    rd0_num = a0;
    rd1_num = a1;
    #1;
  endtask

  initial begin
    // Asynchronous reset asserted away from any clock edge.
    #2;
    reset = 1'b1;
    push_exp("reset_sp", SP_INIT);
    push_exp("reset_ra", RA_INIT);
    read2(5'd29, 5'd31);
    pop_check(rd0_data);
    pop_check(rd1_data);
    push_exp("reset_r5", 32'h0);
    read2(5'd5, 5'd0);
    pop_check(rd0_data);

    // Writes are ignored while reset is high.
    @(negedge clk);
    push_exp("write_in_reset", 32'h0);
    do_write(5'd5, 32'hAAAA_5555);
    read2(5'd5, 5'd0);
    pop_check(rd0_data);
    reset = 1'b0;
    @(negedge clk);

    // Basic write, both ports on the same register.
    push_exp("basic_rd0", 32'hDEAD_BEEF);
    push_exp("basic_rd1", 32'hDEAD_BEEF);
    do_write(5'd8, 32'hDEAD_BEEF);
    read2(5'd8, 5'd8);
    pop_check(rd0_data);
    pop_check(rd1_data);
    push_exp("unchanged_r7", 32'h0);
    push_exp("unchanged_sp", SP_INIT);
    read2(5'd7, 5'd29);
    pop_check(rd0_data);
    pop_check(rd1_data);

    // R0 protection.
    push_exp("r0_rd0", 32'h0);
    push_exp("r0_rd1", 32'h0);
    do_write(5'd0, 32'hFFFF_FFFF);
    read2(5'd0, 5'd0);
    pop_check(rd0_data);
    pop_check(rd1_data);

    // wr_en low leaves state alone.
    wr_num  = 5'd9;
    wr_data = 32'h0000_1234;
    wr_en   = 1'b0;
    @(negedge clk);
    push_exp("wr_en_low", 32'h0);
    read2(5'd9, 5'd8);
    pop_check(rd0_data);

    // Same-cycle read of the register being written.
    do_write(5'd10, 32'h1111_1111);
    rd0_num = 5'd10;
    rd1_num = 5'd10;
    wr_num  = 5'd10;
    wr_data = 32'h2222_2222;
    wr_en   = 1'b1;
`ifdef REGFILE_BYPASS_EN
    push_exp("pre_edge_rd0", 32'h2222_2222);
    push_exp("pre_edge_rd1", 32'h2222_2222);
`else
    push_exp("pre_edge_rd0", 32'h1111_1111);
    push_exp("pre_edge_rd1", 32'h1111_1111);
`endif
    #1;
    pop_check(rd0_data);
    pop_check(rd1_data);
    @(negedge clk);
    wr_en = 1'b0;
    push_exp("post_edge_rd0", 32'h2222_2222);
    push_exp("post_edge_rd1", 32'h2222_2222);
    #1;
    pop_check(rd0_data);
    pop_check(rd1_data);

    // A write to R31 is readable while the other port watches R8.
    push_exp("ra_write", 32'hCAFE_F00D);
    push_exp("r8_kept", 32'hDEAD_BEEF);
    do_write(5'd31, 32'hCAFE_F00D);
    read2(5'd31, 5'd8);
    pop_check(rd0_data);
    pop_check(rd1_data);

    // Reset coincident with a pending write.
    do_write(5'd29, 32'h0);
    do_write(5'd3, 32'h0000_0055);
    push_exp("pre_rst_sp", 32'h0);
    push_exp("pre_rst_r3", 32'h0000_0055);
    read2(5'd29, 5'd3);
    pop_check(rd0_data);
    pop_check(rd1_data);
    wr_num  = 5'd3;
    wr_data = 32'h0000_0077;
    wr_en   = 1'b1;
    @(posedge clk);
    reset = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    push_exp("midop_sp", SP_INIT);
    push_exp("midop_r3", 32'h0);
    read2(5'd29, 5'd3);
    pop_check(rd0_data);
    pop_check(rd1_data);
    push_exp("midop_ra", RA_INIT);
    push_exp("midop_r8", 32'h0);
    read2(5'd31, 5'd8);
    pop_check(rd0_data);
    pop_check(rd1_data);
    reset = 1'b0;
    @(negedge clk);

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
